// File: rtl/dut_format_pack_if.sv
// dut_format_pack_if: packed-word output stream (valid/ready) from the formatter to capture memory.
`default_nettype none

interface dut_format_pack_if #(
   parameter int ADC_MAX_DATA_SIZE = 16,
   parameter int WORD_NUM          = 16
);
   logic [ADC_MAX_DATA_SIZE*WORD_NUM-1:0] o_dut_format_data;
   logic                                  o_dut_format_data_valid;
   logic                                  i_dut_format_data_ready;

   modport master (
      output o_dut_format_data,
      output o_dut_format_data_valid,
      input  i_dut_format_data_ready
   );

   modport slave (
      input  o_dut_format_data,
      input  o_dut_format_data_valid,
      output i_dut_format_data_ready
   );
endinterface

`default_nettype wire

// File: rtl/dut_format_pack.sv
// dut_format_pack: packs a selected run of K ADC channels into WORD_NUM-sample words with capture-length control.
// Optional test-ramp source enabled by defining DUT_FORMAT_RAMP_EN.
`default_nettype none

module dut_format_pack #(
   parameter int ADC_MAX_DATA_SIZE = 16,
   parameter int CHAN_NUM          = 8,
   parameter int WORD_NUM          = 16,
   parameter int CNT_WIDTH         = 24,
   localparam int CB_W             = (CHAN_NUM > 1) ? $clog2(CHAN_NUM) : 1
) (
   input  logic                                  i_dut_format_clk,
   input  logic                                  i_dut_format_reset_n,
   input  logic [ADC_MAX_DATA_SIZE*CHAN_NUM-1:0] i_dut_format_data,
   input  logic                                  i_dut_format_data_valid,
   input  logic                                  i_dut_format_system_rdy,
   input  logic [1:0]                            i_dut_format_mode,
   input  logic [CB_W-1:0]                       i_dut_format_chan_base,
   input  logic [CNT_WIDTH-1:0]                  i_dut_format_word_count,
   input  logic                                  i_dut_format_start,
   input  logic                                  i_dut_format_abort,
`ifdef DUT_FORMAT_RAMP_EN
   input  logic                                  i_dut_format_ramp_en,
`endif
   dut_format_pack_if.master                     out_if,
   output logic                                  o_dut_format_busy,
   output logic                                  o_dut_format_done,
   output logic                                  o_dut_format_overflow
);

   localparam int W      = ADC_MAX_DATA_SIZE;
   localparam int WW     = ADC_MAX_DATA_SIZE * WORD_NUM;
   localparam int FILL_W = $clog2(WORD_NUM) + 1;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_CAPTURE = 2'd1;
   localparam logic [1:0] ST_FLUSH   = 2'd2;

   logic [1:0]           state_q, state_d;
   logic [1:0]           mode_q, mode_d;
   logic [CB_W-1:0]      base_q, base_d;
   logic [CNT_WIDTH-1:0] word_count_q, word_count_d;
   logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
   logic [FILL_W-1:0]    fill_q, fill_d;
   logic                 s1_valid_q, s1_valid_d;
   logic                 s1_last_q, s1_last_d;
   logic [W*CHAN_NUM-1:0] s1_data_q, s1_data_d;
   logic [WW-1:0]        pack_q, pack_d;
   logic                 pack_full_q, pack_full_d;
   logic [WW-1:0]        out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 done_q, done_d;
   logic                 overflow_q, overflow_d;
`ifdef DUT_FORMAT_RAMP_EN
   logic [W-1:0]         ramp_q, ramp_d;
`endif

   function automatic int k_of(input logic [1:0] m);
      int k;
      k = 1 << m;
      if (k > CHAN_NUM) k = CHAN_NUM;
      return k;
   endfunction

   always_comb begin
      int   k_cur;
      int   k_new;
      int   b_new;
      int   fill_next;
      logic accept;

      state_d      = state_q;
      mode_d       = mode_q;
      base_d       = base_q;
      word_count_d = word_count_q;
      word_cnt_d   = word_cnt_q;
      fill_d       = fill_q;
      s1_valid_d   = 1'b0;
      s1_last_d    = 1'b0;
      s1_data_d    = s1_data_q;
      pack_d       = pack_q;
      pack_full_d  = 1'b0;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      done_d       = 1'b0;
      overflow_d   = overflow_q;
`ifdef DUT_FORMAT_RAMP_EN
      ramp_d       = ramp_q;
`endif

      k_cur     = k_of(mode_q);
      k_new     = k_of(i_dut_format_mode);
      b_new     = int'(i_dut_format_chan_base) % CHAN_NUM;
      b_new     = b_new - (b_new % k_new);
      fill_next = int'(fill_q) + k_cur;
      accept    = (state_q == ST_CAPTURE) && i_dut_format_data_valid && i_dut_format_system_rdy;

      // Stage 1: select channels base..base+K-1 into the low K slots
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_data_d  = i_dut_format_data >> (int'(base_q) * W);
         for (int c = 0; c < CHAN_NUM; c++) begin
            if (c >= k_cur) s1_data_d[c*W +: W] = '0;
`ifdef DUT_FORMAT_RAMP_EN
            else if (i_dut_format_ramp_en) s1_data_d[c*W +: W] = ramp_q + W'(int'(base_q) + c);
`endif
         end
`ifdef DUT_FORMAT_RAMP_EN
         ramp_d = ramp_q + W'(1);
`endif
         if (fill_next == WORD_NUM) begin
            fill_d     = '0;
            s1_last_d  = 1'b1;
            word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
            if (word_cnt_d == word_count_q) state_d = ST_FLUSH;
         end else begin
            fill_d = FILL_W'(fill_next);
         end
      end

      // Stage 2: newest group enters at the top so the oldest sample ends in the LSBs
      if (s1_valid_q) begin
         pack_d      = (pack_q >> (k_cur * W)) | (WW'(s1_data_q) << ((WORD_NUM - k_cur) * W));
         pack_full_d = s1_last_q;
      end

      if (pack_full_q) begin
         if (!out_valid_q || out_if.i_dut_format_data_ready) begin
            out_data_d  = pack_q;
            out_valid_d = 1'b1;
         end else begin
            overflow_d = 1'b1;
         end
      end else if (out_if.i_dut_format_data_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         ST_IDLE: begin
            if (i_dut_format_start) begin
`ifdef DUT_FORMAT_RAMP_EN
               ramp_d = '0;
`endif
               if (i_dut_format_word_count != '0) begin
                  state_d      = ST_CAPTURE;
                  mode_d       = i_dut_format_mode;
                  base_d       = CB_W'(b_new);
                  word_count_d = i_dut_format_word_count;
                  word_cnt_d   = '0;
                  fill_d       = '0;
                  overflow_d   = 1'b0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_CAPTURE: ;
         ST_FLUSH: begin
            if (!s1_valid_q && !pack_full_q && (!out_valid_q || out_if.i_dut_format_data_ready)) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides everything except the sticky overflow history
      if (i_dut_format_abort) begin
         state_d     = ST_IDLE;
         s1_valid_d  = 1'b0;
         pack_full_d = 1'b0;
         out_valid_d = 1'b0;
         fill_d      = '0;
         done_d      = 1'b0;
         overflow_d  = overflow_q;
      end
   end

   always_ff @(posedge i_dut_format_clk or negedge i_dut_format_reset_n) begin
      if (!i_dut_format_reset_n) begin
         state_q      <= ST_IDLE;
         mode_q       <= '0;
         base_q       <= '0;
         word_count_q <= '0;
         word_cnt_q   <= '0;
         fill_q       <= '0;
         s1_valid_q   <= 1'b0;
         s1_last_q    <= 1'b0;
         s1_data_q    <= '0;
         pack_q       <= '0;
         pack_full_q  <= 1'b0;
         out_data_q   <= '0;
         out_valid_q  <= 1'b0;
         done_q       <= 1'b0;
         overflow_q   <= 1'b0;
`ifdef DUT_FORMAT_RAMP_EN
         ramp_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         base_q       <= base_d;
         word_count_q <= word_count_d;
         word_cnt_q   <= word_cnt_d;
         fill_q       <= fill_d;
         s1_valid_q   <= s1_valid_d;
         s1_last_q    <= s1_last_d;
         s1_data_q    <= s1_data_d;
         pack_q       <= pack_d;
         pack_full_q  <= pack_full_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         done_q       <= done_d;
         overflow_q   <= overflow_d;
`ifdef DUT_FORMAT_RAMP_EN
         ramp_q       <= ramp_d;
`endif
      end
   end

   assign out_if.o_dut_format_data       = out_data_q;
   assign out_if.o_dut_format_data_valid = out_valid_q;
   assign o_dut_format_busy              = (state_q != ST_IDLE);
   assign o_dut_format_done              = done_q;
   assign o_dut_format_overflow          = overflow_q;

endmodule

`default_nettype wire
